// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_buffered_tx_if.sv
// Host-side write port and status/serial outputs of the buffered UART transmitter.
interface uart_buffered_tx_if #(
  parameter int unsigned DEPTH = 16
) ();
  import uart_pkg::*;

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [UART_DATA_BITS-1:0] wr_data;
  logic                      wr_en;
  logic                      full;
  logic [CNT_W-1:0]          count;
  logic                      overflow;
  logic                      busy;
  logic                      tx;

  modport master (output wr_data, wr_en, input full, count, overflow, busy, tx);
  modport slave  (input wr_data, wr_en, output full, count, overflow, busy, tx);

endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered full/empty/count.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             push_data_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             pop_data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             push_ok, pop_ok;

  // Flags are registered, so a push while full is refused even if a pop lands on the same edge.
  assign push_ok = push_i && !full_q;
  assign pop_ok  = pop_i && !empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_ok && !pop_ok)      cnt_d = cnt_q + CNT_W'(1);
    else if (!push_ok && pop_ok) cnt_d = cnt_q - CNT_W'(1);
    full_d  = (cnt_d == CNT_W'(DEPTH));
    empty_d = (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign full_o     = full_q;
  assign empty_o    = empty_q;
  assign count_o    = cnt_q;

endmodule

// File: rtl/uart_buffered_tx.sv
// Buffered 8N1 UART transmitter: FIFO feeding a baud-counter driven frame FSM.
module uart_buffered_tx #(
  parameter int unsigned BAUD_DIV = 2083,
  parameter int unsigned DEPTH    = 16
) (
  input  logic                clk,
  input  logic                reset,
  uart_buffered_tx_if.slave   bus
);
  import uart_pkg::*;

  localparam int unsigned BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned IDX_W  = $clog2(UART_DATA_BITS);
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

  tx_state_t                 state_q, state_d;
  logic [BAUD_W-1:0]         baud_q, baud_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      tx_q, tx_d;
  logic                      busy_q, busy_d;
  logic                      overflow_q, overflow_d;
  logic                      tick, pop, push_ok;

  logic [UART_DATA_BITS-1:0] fifo_rd_data;
  logic                      fifo_full, fifo_empty;
  logic [CNT_W-1:0]          fifo_count;

  uart_sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (bus.wr_en),
    .push_data_i (bus.wr_data),
    .pop_i       (pop),
    .pop_data_o  (fifo_rd_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign tick    = (baud_q == BAUD_W'(BAUD_DIV - 1));
  assign push_ok = bus.wr_en && !fifo_full;

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    pop        = 1'b0;
    overflow_d = overflow_q | (bus.wr_en & fifo_full);

    if (state_q != IDLE) baud_d = tick ? '0 : baud_q + BAUD_W'(1);

    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!fifo_empty) pop = 1'b1;
      end
      START: if (tick) state_d = DATA;
      DATA: begin
        if (tick) begin
          if (idx_q == IDX_W'(UART_DATA_BITS - 1)) begin
            state_d = STOP;
          end else begin
            shift_d = shift_q >> 1;
            idx_d   = idx_q + IDX_W'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (!fifo_empty) pop = 1'b1;
          else             state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Every pop (from IDLE or straight out of STOP) starts a fresh frame.
    if (pop) begin
      shift_d = fifo_rd_data;
      baud_d  = '0;
      idx_d   = '0;
      state_d = START;
    end

    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase

    // Entering IDLE implies no pop this edge, so the FIFO is non-empty only via a new push.
    busy_d = (state_d != IDLE) || (fifo_count != '0) || push_ok;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.tx       = tx_q;
  assign bus.busy     = busy_q;
  assign bus.overflow = overflow_q;
  assign bus.full     = fifo_full;
  assign bus.count    = fifo_count;

endmodule

// File: tb/tb_uart_buffered_tx.sv
// Self-checking bench for uart_buffered_tx against a frame-level queue model.
module tb_uart_buffered_tx;

  localparam int unsigned BD    = 4;
  localparam int unsigned DP    = 16;
  localparam int          FRAME = 10 * BD;

  logic clk;
  logic reset;

  uart_buffered_tx_if #(.DEPTH(DP)) bus ();

  uart_buffered_tx #(.BAUD_DIV(BD), .DEPTH(DP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: queue of pending bytes plus position inside the frame currently on the wire.
  logic [7:0] mq[$];
  bit         m_active;
  int         m_pos;
  logic [7:0] m_cur;
  bit         m_ovf;

  function automatic logic m_tx();
    int b;
    if (!m_active)           return 1'b1;
    if (m_pos < int'(BD))    return 1'b0;
    if (m_pos < 9 * int'(BD)) begin
      b = (m_pos - int'(BD)) / int'(BD);
      return m_cur[3'(b)];
    end
    return 1'b1;
  endfunction

  function automatic void m_edge(input logic we, input logic [7:0] d, input logic rst);
    bit was_full, was_empty;
    if (rst) begin
      mq.delete();
      m_active = 1'b0;
      m_pos    = 0;
      m_ovf    = 1'b0;
      return;
    end
    was_full  = (mq.size() == int'(DP));
    was_empty = (mq.size() == 0);
    if (m_active) begin
      m_pos++;
      if (m_pos == FRAME) begin
        if (!was_empty) begin
          m_cur = mq.pop_front();
          m_pos = 0;
        end else begin
          m_active = 1'b0;
        end
      end
    end else if (!was_empty) begin
      m_cur    = mq.pop_front();
      m_active = 1'b1;
      m_pos    = 0;
    end
    if (we) begin
      if (was_full) m_ovf = 1'b1;
      else          mq.push_back(d);
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock edge: drive, advance model, then compare every output 1 time unit later.
  task automatic cyc(input logic we, input logic [7:0] d, input logic rst);
    bus.wr_en   = we;
    bus.wr_data = d;
    reset       = rst;
    @(posedge clk);
    m_edge(we, d, rst);
    #1;
    chk("tx",       32'(bus.tx),       32'(m_tx()));
    chk("count",    32'(bus.count),    32'(mq.size()));
    chk("full",     32'(bus.full),     32'(mq.size() == int'(DP)));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    chk("busy",     32'(bus.busy),     32'(m_active || mq.size() != 0));
    bus.wr_en = 1'b0;
    reset     = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0);
  endtask

  task automatic wait_pos(input int target);
    int k;
    k = 0;
    while (!(m_active && m_pos == target) && k < 200) begin
      cyc(1'b0, 8'h00, 1'b0);
      k++;
    end
    if (k == 200) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_pos timeout target=%0d", target);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0]  f55;
    logic [19:0] f2;
    f55 = {1'b1, 8'h55, 1'b0};
    f2  = {1'b1, 8'h0F, 1'b0, 1'b1, 8'hA3, 1'b0};

    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    reset       = 1'b1;

    // Reset state
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    chk("rst_tx", 32'(bus.tx), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    idle(3);

    // Single byte 0x55
    cyc(1'b1, 8'h55, 1'b0);
    chk("t1_count", 32'(bus.count), 32'd1);
    chk("t1_tx_e0", 32'(bus.tx), 32'd1);
    for (int i = 1; i <= FRAME; i++) begin
      cyc(1'b0, 8'h00, 1'b0);
      chk("t1_frame", 32'(bus.tx), 32'(f55[(i - 1) / int'(BD)]));
      if (i == FRAME) chk("t1_busy_e40", 32'(bus.busy), 32'd1);
    end
    cyc(1'b0, 8'h00, 1'b0);
    chk("t1_busy_e41", 32'(bus.busy), 32'd0);
    idle(3);

    // Back-to-back 0xA3, 0x0F
    cyc(1'b1, 8'hA3, 1'b0);
    cyc(1'b1, 8'h0F, 1'b0);
    chk("t2_frames", 32'(bus.tx), 32'(f2[0]));
    for (int i = 2; i <= 2 * FRAME; i++) begin
      cyc(1'b0, 8'h00, 1'b0);
      chk("t2_frames", 32'(bus.tx), 32'(f2[(i - 1) / int'(BD)]));
    end
    cyc(1'b0, 8'h00, 1'b0);
    chk("t2_idle_tx", 32'(bus.tx), 32'd1);
    chk("t2_idle_busy", 32'(bus.busy), 32'd0);

    // Fill to full, then one dropped write
    for (int i = 0; i < 17; i++) cyc(1'b1, 8'($urandom), 1'b0);
    chk("t3_count", 32'(bus.count), 32'd16);
    chk("t3_full", 32'(bus.full), 32'd1);
    chk("t3_ovf", 32'(bus.overflow), 32'd0);
    cyc(1'b1, 8'hEE, 1'b0);
    chk("t3_ovf18", 32'(bus.overflow), 32'd1);
    chk("t3_count18", 32'(bus.count), 32'd16);
    idle(17 * FRAME + 5);
    chk("t3_drained", 32'(bus.busy), 32'd0);

    // Write while full on the STOP-to-START pop edge
    cyc(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 17; i++) cyc(1'b1, 8'($urandom), 1'b0);
    chk("t4_full", 32'(bus.full), 32'd1);
    wait_pos(FRAME - 1);
    cyc(1'b1, 8'h5A, 1'b0);
    chk("t4_count", 32'(bus.count), 32'd15);
    chk("t4_ovf", 32'(bus.overflow), 32'd1);
    chk("t4_tx_start", 32'(bus.tx), 32'd0);

    // Reset during DATA bit 3 of the next frame
    wait_pos(int'(BD) + 3 * int'(BD) + 1);
    cyc(1'b0, 8'h00, 1'b1);
    chk("t5_tx", 32'(bus.tx), 32'd1);
    chk("t5_count", 32'(bus.count), 32'd0);
    chk("t5_busy", 32'(bus.busy), 32'd0);
    chk("t5_ovf", 32'(bus.overflow), 32'd0);
    cyc(1'b1, 8'hC6, 1'b0);
    idle(FRAME + 5);
    chk("t5_done", 32'(bus.busy), 32'd0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 3) == 0), 8'($urandom), ($urandom_range(0, 299) == 0));
    end
    idle(int'(DP) * FRAME + 50);
    chk("t6_idle", 32'(bus.busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_buffered_tx.md
# uart_buffered_tx

Buffered UART transmitter sending 8 data bits, no parity, one stop bit, LSB first. It runs entirely in the module clock domain and derives bit timing from an internal baud counter, with no divided clock. Bytes are pushed into an internal FIFO by host logic such as the command processor and telemetry packers. Frames are sent back-to-back with no idle gap while the FIFO holds data. It pairs with the existing UART receiver on the same serial link.

## Interface
Parameters:
- BAUD_DIV, 2083: module-clock cycles per bit. Must be at least 2.
- DEPTH, 16: FIFO entries. Must be a power of 2 and at least 2.

Ports:
- clk  in  1  module clock. The only clock.
- reset  in  1  synchronous, active-high reset.
- wr_data  in  8  byte to enqueue.
- wr_en  in  1  enqueue request, sampled on the clk rising edge.
- full  out  1  FIFO holds DEPTH entries.
- count  out  $clog2(DEPTH+1)  number of FIFO entries.
- overflow  out  1  sticky flag: a write was attempted while full.
- busy  out  1  high when the state is not IDLE or count is nonzero.
- tx  out  1  serial line. Idles high.

## Operation
- Write acceptance:
  - wr_en && !full stores wr_data at the write pointer, and the pointer advances modulo DEPTH.
  - wr_en && full drops the byte and sets overflow. overflow is cleared only by reset.
- FSM states, tx_state_t: IDLE, START, DATA, STOP.
  - IDLE: if count != 0, pop the head into the shift register, clear the baud counter and bit index, and go to START. tx = 1.
  - START: tx = 0 for BAUD_DIV cycles, then go to DATA.
  - DATA: tx = shift[0]. Every BAUD_DIV cycles, shift right and increment the bit index. After bit 7 has been held for its full period, go to STOP.
  - STOP: tx = 1 for BAUD_DIV cycles. At the end of the period:
    - if count != 0, pop and go straight to START (back-to-back);
    - otherwise go to IDLE.
- Baud counter:
  - Counts 0..BAUD_DIV-1, and the bit tick fires when it equals BAUD_DIV-1.
  - It is held at 0 in IDLE and is cleared on every pop.
- FIFO count arithmetic:
  - Simultaneous accepted write and pop leaves count unchanged.
  - full and count reflect the registered state. A write while full is rejected even if a pop occurs on the same edge.
- tx is a registered output with no combinational path from any input.
- Reset mid-frame aborts the frame. tx returns high on that edge, and the truncated frame is not retried.

## Timing
- Reset values:
  - tx = 1, busy = 0, full = 0, count = 0, overflow = 0.
  - State = IDLE, pointers = 0, baud counter = 0.
- Latency: for a write accepted at edge k with the FSM in IDLE and the FIFO empty:
  - count = 1 after edge k;
  - the pop and tx falling both occur at edge k+1.
- Frame length: exactly 10*BAUD_DIV cycles from tx falling to the end of the stop bit.
- Back-to-back: the next start bit begins on the edge immediately after the stop period ends, with no extra idle cycles.
- busy falls on the edge that enters IDLE with count = 0.

## Structure
- Package uart_pkg holds:
  - typedef enum tx_state_t {IDLE, START, DATA, STOP};
  - localparam UART_DATA_BITS = 8.
- One sub-module, uart_sync_fifo, parameterised by WIDTH and DEPTH:
  - single clock, synchronous reset;
  - push/pop interface with full, empty and count;
  - pop on empty is ignored.
- Top level contains the FSM, the baud counter, the shift register and the overflow flag.

## Test plan
All scenarios use BAUD_DIV = 4 and DEPTH = 16.
- Single byte: write 0x55 at edge 0.
  - tx low at edge 1, then 0,1,0,1,0,1,0,1,0,1, each level held exactly 4 cycles.
  - busy falls at edge 41.
- Back-to-back: write 0xA3 then 0x0F on consecutive edges.
  - Two contiguous frames over 80 cycles, with bits LSB first: 1,1,0,0,0,1,0,1 then 1,1,1,1,0,0,0,0.
  - tx high only for the 4 stop-bit cycles between the frames.
- Full and overflow: 17 writes on consecutive edges from idle.
  - After them: count = 16, full = 1, overflow = 0.
  - An 18th write is dropped, overflow = 1, and count stays 16.
  - The first 17 bytes are transmitted in order.
- Simultaneous events: while full, assert wr_en on the same edge as a STOP-to-START pop.
  - The write is rejected, count becomes 15 and overflow = 1.
- Reset mid-frame: assert reset during DATA bit 3.
  - Next edge: tx = 1, count = 0, busy = 0, overflow = 0.
  - A write afterwards produces a clean frame.
